// File: rtl/bram_tdp_be.sv
// rtl/bram_tdp_be.sv - true dual-port RAM with byte enables, selectable latency and clear sequencer
module bram_tdp_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_a,
  input  logic [ADDR_WIDTH-1:0]            i_addr_a,
  input  logic [DATA_WIDTH-1:0]            i_data_a,
  output logic [DATA_WIDTH-1:0]            o_data_a,
  output logic                             o_valid_a,
  input  logic                             i_en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_b,
  input  logic [ADDR_WIDTH-1:0]            i_addr_b,
  input  logic [DATA_WIDTH-1:0]            i_data_b,
  output logic [DATA_WIDTH-1:0]            o_data_b,
  output logic                             o_valid_b,
  input  logic                             i_clear,
  output logic                             o_busy,
  output logic                             o_collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc_a, acc_b;
  logic [DATA_WIDTH-1:0]   old_a, old_b, merge_a, merge_b, rd_a, rd_b;
  logic                    collision_d, collision_q;
  logic [DATA_WIDTH-1:0]   d1_a_q, d1_b_q;
  logic                    v1_a_q, v1_b_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (i_clear) state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset is folded in so a port cannot write while reset is held.
  assign acc_a = (state_q == S_IDLE) && i_en_a && !i_rst;
  assign acc_b = (state_q == S_IDLE) && i_en_b && !i_rst;

  assign old_a = mem[i_addr_a];
  assign old_b = mem[i_addr_b];

  always_comb begin
    merge_a = old_a;
    merge_b = old_b;
    for (int k = 0; k < NB; k++) begin
      if (i_we_a[k]) merge_a[k*BYTE_WIDTH +: BYTE_WIDTH] = i_data_a[k*BYTE_WIDTH +: BYTE_WIDTH];
      if (i_we_b[k]) merge_b[k*BYTE_WIDTH +: BYTE_WIDTH] = i_data_b[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign rd_a = (WRITE_MODE == 1) ? merge_a : old_a;
  assign rd_b = (WRITE_MODE == 1) ? merge_b : old_b;

  assign collision_d = acc_a && acc_b && (i_addr_a == i_addr_b) && (|(i_we_a & i_we_b));

  // Port B lanes are written first so overlapping port A lanes win.
  always_ff @(posedge i_clk) begin
    if (state_q == S_CLEAR && !i_rst) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (acc_b && i_we_b[k])
          mem[i_addr_b][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_data_b[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int k = 0; k < NB; k++) begin
        if (acc_a && i_we_a[k])
          mem[i_addr_a][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_data_a[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d1_a_q      <= '0;
      d1_b_q      <= '0;
      v1_a_q      <= 1'b0;
      v1_b_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      v1_a_q      <= acc_a;
      v1_b_q      <= acc_b;
      collision_q <= collision_d;
      if (acc_a) d1_a_q <= rd_a;
      if (acc_b) d1_b_q <= rd_b;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] d2_a_q, d2_b_q;
      logic                  v2_a_q, v2_b_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          d2_a_q <= '0;
          d2_b_q <= '0;
          v2_a_q <= 1'b0;
          v2_b_q <= 1'b0;
        end else begin
          v2_a_q <= v1_a_q;
          v2_b_q <= v1_b_q;
          if (v1_a_q) d2_a_q <= d1_a_q;
          if (v1_b_q) d2_b_q <= d1_b_q;
        end
      end

      assign o_data_a  = d2_a_q;
      assign o_data_b  = d2_b_q;
      assign o_valid_a = v2_a_q;
      assign o_valid_b = v2_b_q;
    end else begin : g_lat1
      assign o_data_a  = d1_a_q;
      assign o_data_b  = d1_b_q;
      assign o_valid_a = v1_a_q;
      assign o_valid_b = v1_b_q;
    end
  endgenerate

  assign o_busy      = (state_q == S_CLEAR);
  assign o_collision = collision_q;

endmodule

// File: doc/bram_tdp_be.md
Name: bram_tdp_be

Overview:
Single-clock true dual-port block RAM, the parametrised successor of the existing two-port bram. It adds per-byte write enables, selectable read latency (1 or 2), a selectable same-port read-during-write mode, and deterministic same-address write collision resolution with a flag. A built-in clear sequencer zeroes the whole array on request. Used as shared scratch/register-file memory between two masters in one clock domain.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
ADDR_WIDTH, 12, address bits; depth = 2**ADDR_WIDTH words.
BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
READ_LATENCY, 1, cycles from the sampling edge to o_data/o_valid; legal values 1 or 2.
WRITE_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged word).

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous active-high reset.
i_en_a  in  1  port A access request this cycle.
i_we_a  in  NB  port A byte write enables; all zero = pure read.
i_addr_a  in  ADDR_WIDTH  port A word address.
i_data_a  in  DATA_WIDTH  port A write data.
o_data_a  out  DATA_WIDTH  port A read data.
o_valid_a  out  1  one-cycle pulse: o_data_a holds the result of an accepted access.
i_en_b, i_we_b, i_addr_b, i_data_b, o_data_b, o_valid_b  as port A, for port B.
i_clear  in  1  request a full-array zero fill.
o_busy  out  1  clear sequence in progress; ports ignored.
o_collision  out  1  one-cycle pulse: both ports wrote overlapping bytes of one address.

Behaviour:
- Reset (async, i_rst=1): o_data_a/b=0, o_valid_a/b=0, o_busy=0, o_collision=0, FSM=IDLE, clear counter=0, latency pipeline cleared. Memory contents are not reset.
- Access acceptance: on a rising edge with FSM=IDLE and i_en_x=1. With i_en_x=0, o_data_x holds its previous value and o_valid_x=0.
- Write: each byte lane k with i_we_x[k]=1 is written from i_data_x; the other lanes are unchanged.
- Every accepted access returns a read word. Pure read gives stored data. Write access gives the old word (WRITE_MODE=0) or the merged new word (WRITE_MODE=1).
- Latency: READ_LATENCY=1, data and valid are registered at the accepting edge. READ_LATENCY=2 adds one output register stage; the valid pipeline tracks the data exactly. Back-to-back accesses are fully pipelined with throughput of 1 per cycle per port.
- Cross-port, same address, same cycle: a read on one port with a write on the other returns old data.
- Write/write, same address: lanes written by both ports take port A data. Lanes written by only one port take that port's data. If any lane overlaps, o_collision=1 for the next cycle. Different addresses never flag.
- Clear FSM:
  - IDLE->CLEAR when i_clear=1 at an edge in IDLE. Port requests on that same edge are still accepted.
  - CLEAR writes 0 to counter address 0..DEPTH-1, one word per cycle. o_busy=1 from the cycle after entry through the final write. Port enables are ignored and o_valid_x stays 0.
  - After address DEPTH-1 is written: counter resets to 0, FSM->IDLE, o_busy=0 the next cycle. The clear takes exactly DEPTH cycles.
  - i_clear while in CLEAR is ignored.
  - Reset mid-clear aborts to IDLE; already-cleared words stay 0 and the rest are unchanged.
- Addresses use only ADDR_WIDTH bits; there is no out-of-range case.

Test Plan:
1. Byte lanes (default params): A writes 0xAABBCCDD to addr 5 (we=1111), then A writes 0x11223344 with we=0101. A read of addr 5 -> 0xAA22CC44, o_valid_a pulse 1 cycle after the accepting edge.
2. Latency/pipelining: READ_LATENCY=2. Preload addrs 0..3 with 0x10..0x13. Port B reads 0,1,2,3 back-to-back -> o_data_b = 0x10,0x11,0x12,0x13 on consecutive cycles, starting 2 cycles after the first edge.
3. Read-during-write: addr 7 holds 0x1. A writes 0x2 to addr 7 with we=1111 while B reads addr 7 in the same cycle. WRITE_MODE=0 -> o_data_a=0x1; WRITE_MODE=1 -> o_data_a=0x2; both modes -> o_data_b=0x1.
4. Collision: A writes 0xAAAAAAAA (we=0011) and B writes 0xBBBBBBBB (we=0110) to addr 9 in the same cycle -> o_collision pulses 1 cycle; addr 9 reads 0x00BBAAAA from a zeroed start.
5. Clear: ADDR_WIDTH=4, fill all words with 0xFFFFFFFF, pulse i_clear -> o_busy high for exactly 16 cycles, port reads during busy give no o_valid, all 16 words then read 0.
6. Reset mid-clear: ADDR_WIDTH=4 full of 0xFF, assert i_rst after 5 clear cycles -> o_busy=0 immediately, addrs 0..4 read 0, addrs 5..15 read 0xFF.
